// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: frame state encoding,
// per-byte handshake phase, default start-of-frame marker and checksum width.
// No ports; imported by uart_byte_fifo users and uart_tx_framer.
package uart_pkg;

  // Frame sequence: IDLE -> SOF -> LEN -> PAYLOAD -> (CHK) -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } frame_state_e;

  // Per-byte handshake with the transmitter
  typedef enum logic {
    PH_ISSUE = 1'b0,  // DV high, waiting for the transmitter to go active
    PH_WAIT  = 1'b1   // DV low, waiting for the transmitter to go idle again
  } byte_phase_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
  localparam int         CHK_W            = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Purpose : synchronous byte FIFO, first-word-fall-through read port, no frame logic.
// Latency : push visible on rd_dat/count one cycle after the write edge.
// Backpr. : pushes while full are dropped and flagged by a one-cycle overflow pulse.
// Ports   : clk, rst (sync, active-high), push_vld/push_dat, pop_vld, rd_dat,
//           full, empty, count (ADDR_W+1 bits), overflow.
module uart_byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop_vld,
  output logic [DATA_W-1:0] rd_dat,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;

  // Fullness is judged on the registered count, so a same-cycle pop never
  // rescues a write into a full FIFO.
  assign do_push = push_vld && (count_q != FULL_CNT);
  assign do_pop  = pop_vld && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push_vld && (count_q == FULL_CNT);
    // Pointers are ADDR_W wide, so increment wraps modulo DEPTH
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign rd_dat   = mem_q[rd_ptr_q];
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_framer.sv
// Purpose : buffers payload bytes and sends them as SOF, LEN, payload[, XOR checksum] frames.
// Latency : i_Send accepted in cycle N -> o_Tx_DV high in cycle N+1.
// Backpr. : each byte waits for the transmitter active flag to rise then fall; no timeout.
// Ports   : i_Clock, i_Reset (sync, active-high); write side i_Wr_DV/i_Wr_Byte with
//           o_Full/o_Empty/o_Count/o_Overflow; control i_Send, o_Busy, o_Frame_Done;
//           transmitter side o_Tx_DV/o_Tx_Byte, i_Tx_Active.
// Option  : define UART_TX_FRAMER_CHECKSUM_EN to append the checksum (LEN ^ payload) byte.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEFAULT
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Wr_DV,
  input  logic [7:0]      i_Wr_Byte,
  input  logic            i_Send,
  output logic            o_Full,
  output logic            o_Empty,
  output logic [ADDR_W:0] o_Count,
  output logic            o_Overflow,
  output logic            o_Busy,
  output logic            o_Frame_Done,
  output logic            o_Tx_DV,
  output logic [7:0]      o_Tx_Byte,
  input  logic            i_Tx_Active
);

  logic            fifo_pop;
  logic [7:0]      fifo_rd_dat;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic [7:0]      count_byte;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .push_vld (i_Wr_DV),
    .push_dat (i_Wr_Byte),
    .pop_vld  (fifo_pop),
    .rd_dat   (fifo_rd_dat),
    .full     (o_Full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (o_Overflow)
  );

  assign count_byte = 8'(fifo_count);

  frame_state_e state_q, state_d;
  byte_phase_e  phase_q, phase_d;
  logic [7:0]   rem_q, rem_d;      // LEN at accept, counts down per payload pop
  logic         tx_dv_q, tx_dv_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
  logic [CHK_W-1:0] chk_q, chk_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    tx_dv_d   = tx_dv_q;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
    chk_d     = chk_q;
`endif

    if (state_q == ST_IDLE) begin
      // Transmitter must be idle too, so a byte left over from a reset
      // mid-frame cannot overlap the new SOF.
      if (i_Send && !fifo_empty && !i_Tx_Active) begin
        state_d   = ST_SOF;
        phase_d   = PH_ISSUE;
        tx_dv_d   = 1'b1;
        tx_byte_d = SOF_BYTE;
        rem_d     = count_byte;
        busy_d    = 1'b1;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
        chk_d     = count_byte;
`endif
      end
    end else if (phase_q == PH_ISSUE) begin
      if (i_Tx_Active) begin
        tx_dv_d = 1'b0;
        phase_d = PH_WAIT;
      end
    end else if (!i_Tx_Active) begin
      // Byte complete: set up the next byte's ISSUE or finish the frame
      phase_d = PH_ISSUE;
      case (state_q)
        ST_SOF: begin
          state_d   = ST_LEN;
          tx_dv_d   = 1'b1;
          tx_byte_d = rem_q;
        end
        ST_LEN, ST_PAYLOAD: begin
          // LEN is never 0, so LEN always leads into at least one pop
          if (state_q == ST_LEN || rem_q != 8'd0) begin
            state_d   = ST_PAYLOAD;
            fifo_pop  = 1'b1;
            tx_dv_d   = 1'b1;
            tx_byte_d = fifo_rd_dat;
            rem_d     = rem_q - 8'd1;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            chk_d     = chk_q ^ fifo_rd_dat;
`endif
          end else begin
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            state_d   = ST_CHK;
            tx_dv_d   = 1'b1;
            tx_byte_d = chk_q;
`else
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_ISSUE;
      rem_q     <= 8'd0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign o_Empty      = fifo_empty;
  assign o_Count      = fifo_count;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = done_q;
  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;

endmodule
